// File: rtl/masked_share_encoder.sv
// Boolean masking front end: splits X/Y into two shares with fresh randomness,
// refreshes them REFRESH_ROUNDS times and hands x0/x1/y0/y1 to a masked AND gadget.
module masked_share_encoder #(
   parameter int WIDTH          = 4,
   parameter int REFRESH_ROUNDS = 1,
   parameter int CNT_W          = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     x,
   input  logic [WIDTH-1:0]     y,
   input  logic                 rnd_valid,
   output logic                 rnd_ready,
   input  logic [2*WIDTH-1:0]   rnd,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     x0,
   output logic [WIDTH-1:0]     x1,
   output logic [WIDTH-1:0]     y0,
   output logic [WIDTH-1:0]     y1,
   output logic [CNT_W-1:0]     rnd_cnt
);

   typedef enum logic [2:0] {
      IDLE, LOAD_RND, COMBINE, REFRESH, LATCH, RELEASE, OUT
   } state_e;

   state_e state_q, state_d;
   logic   init_q, init_d;

   logic [WIDTH-1:0] xs_q, xs_d, ys_q, ys_d;
   logic [WIDTH-1:0] sx0_q, sx0_d, sx1_q, sx1_d, sy0_q, sy0_d, sy1_q, sy1_d;
   logic [WIDTH-1:0] ox0_q, ox0_d, ox1_q, ox1_d, oy0_q, oy0_d, oy1_q, oy1_d;
   logic [2:0]       round_q, round_d;
   logic [CNT_W-1:0] rnd_cnt_q, rnd_cnt_d;

   logic [WIDTH-1:0] rx, ry;
   logic             in_fire, rnd_fire, out_fire, last_round;

   assign rx = rnd[WIDTH-1:0];
   assign ry = rnd[2*WIDTH-1:WIDTH];

   // in_ready stays low until the first edge after reset release.
   assign in_ready  = init_q && (state_q == IDLE);
   assign rnd_ready = (state_q == LOAD_RND) || (state_q == REFRESH);
   assign out_valid = (state_q == OUT);

   assign in_fire    = in_valid  && in_ready;
   assign rnd_fire   = rnd_valid && rnd_ready;
   assign out_fire   = out_valid && out_ready;
   assign last_round = (({1'b0, round_q} + 4'd1) == 4'(REFRESH_ROUNDS));

   // Output registers are loaded one cycle before OUT, so they are masked here.
   assign x0      = (state_q == OUT) ? ox0_q : '0;
   assign x1      = (state_q == OUT) ? ox1_q : '0;
   assign y0      = (state_q == OUT) ? oy0_q : '0;
   assign y1      = (state_q == OUT) ? oy1_q : '0;
   assign rnd_cnt = rnd_cnt_q;

   always_comb begin
      // NOTE: every _d gets its hold value first, so no branch can infer a latch.
      state_d   = state_q;
      init_d    = 1'b1;
      xs_d      = xs_q;
      ys_d      = ys_q;
      sx0_d     = sx0_q;
      sx1_d     = sx1_q;
      sy0_d     = sy0_q;
      sy1_d     = sy1_q;
      ox0_d     = ox0_q;
      ox1_d     = ox1_q;
      oy0_d     = oy0_q;
      oy1_d     = oy1_q;
      round_d   = round_q;
      rnd_cnt_d = rnd_cnt_q;

      if (rnd_fire && (rnd_cnt_q != '1)) rnd_cnt_d = rnd_cnt_q + CNT_W'(1);

      case (state_q)
         IDLE: begin
            if (in_fire) begin
               xs_d    = x;
               ys_d    = y;
               round_d = '0;
               state_d = LOAD_RND;
            end
         end
         LOAD_RND: begin
            if (rnd_fire) begin
               sx1_d   = rx;
               sy1_d   = ry;
               state_d = COMBINE;
            end
         end
         COMBINE: begin
            // The only secret/share cross-term; it lands in sx0/sy0 and the secrets die here.
            sx0_d   = xs_q ^ sx1_q;
            sy0_d   = ys_q ^ sy1_q;
            xs_d    = '0;
            ys_d    = '0;
            state_d = (REFRESH_ROUNDS == 0) ? LATCH : REFRESH;
         end
         REFRESH: begin
            if (rnd_fire) begin
               sx0_d   = sx0_q ^ rx;
               sx1_d   = sx1_q ^ rx;
               sy0_d   = sy0_q ^ ry;
               sy1_d   = sy1_q ^ ry;
               round_d = round_q + 3'd1;
               if (last_round) state_d = LATCH;
            end
         end
         LATCH: begin
            ox0_d   = sx0_q;
            ox1_d   = sx1_q;
            oy0_d   = sy0_q;
            oy1_d   = sy1_q;
            sx0_d   = '0;
            sx1_d   = '0;
            sy0_d   = '0;
            sy1_d   = '0;
            state_d = RELEASE;
         end
         RELEASE: state_d = OUT;
         OUT: begin
            if (out_fire) begin
               ox0_d   = '0;
               ox1_d   = '0;
               oy0_d   = '0;
               oy1_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         init_q    <= 1'b0;
         xs_q      <= '0;
         ys_q      <= '0;
         sx0_q     <= '0;
         sx1_q     <= '0;
         sy0_q     <= '0;
         sy1_q     <= '0;
         ox0_q     <= '0;
         ox1_q     <= '0;
         oy0_q     <= '0;
         oy1_q     <= '0;
         round_q   <= '0;
         rnd_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         init_q    <= init_d;
         xs_q      <= xs_d;
         ys_q      <= ys_d;
         sx0_q     <= sx0_d;
         sx1_q     <= sx1_d;
         sy0_q     <= sy0_d;
         sy1_q     <= sy1_d;
         ox0_q     <= ox0_d;
         ox1_q     <= ox1_d;
         oy0_q     <= oy0_d;
         oy1_q     <= oy1_d;
         round_q   <= round_d;
         rnd_cnt_q <= rnd_cnt_d;
      end
   end

endmodule

// File: tb/tb_masked_share_encoder.sv
// Scoreboard bench for masked_share_encoder: three instances (R=1, R=0, R=1 with a
// 2-bit counter), randomized transactions checked against an XOR-of-randomness model.
`timescale 1ns/1ps
module tb_masked_share_encoder;

   localparam int N = 3;
   localparam int W = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic           in_valid [N];
   logic           rnd_valid[N];
   logic           out_ready[N];
   logic           in_ready [N];
   logic           rnd_ready[N];
   logic           out_valid[N];
   logic [W-1:0]   x0[N], x1[N], y0[N], y1[N];
   logic [15:0]    cnt[N];
   logic [W-1:0]   x, y;
   logic [2*W-1:0] rnd;

   function automatic int rr(int i);
      return (i == 1) ? 0 : 1;
   endfunction

   function automatic int cmax(int i);
      return (i == 2) ? 3 : 65535;
   endfunction

   for (genvar g = 0; g < N; g++) begin : g_dut
      localparam int RG = (g == 1) ? 0 : 1;
      localparam int CG = (g == 2) ? 2 : 16;
      logic [CG-1:0] c;
      masked_share_encoder #(.WIDTH(W), .REFRESH_ROUNDS(RG), .CNT_W(CG)) dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .x         (x),
         .y         (y),
         .rnd_valid (rnd_valid[g]),
         .rnd_ready (rnd_ready[g]),
         .rnd       (rnd),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .x0        (x0[g]),
         .x1        (x1[g]),
         .y0        (y0[g]),
         .y1        (y1[g]),
         .rnd_cnt   (c)
      );
      assign cnt[g] = 16'(c);
   end

   typedef struct {
      int          inst;
      logic [15:0] shares;
      int          rise;
      logic [15:0] cnt;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;
   int   cnt_model[N];
   logic ov_prev[N];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: compares whatever each DUT presents against the scoreboard head.
   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (out_valid[i]) begin
            if (sb.size() == 0 || sb[0].inst != i) begin
               check("unexpected_out_valid", 32'(out_valid[i]), 32'd0);
            end else begin
               check("shares", 32'({x0[i], x1[i], y0[i], y1[i]}), 32'(sb[0].shares));
               if (!ov_prev[i]) begin
                  check("latency", cyc, sb[0].rise);
                  check("rnd_cnt", 32'(cnt[i]), 32'(sb[0].cnt));
               end
               if (out_ready[i]) void'(sb.pop_front());
            end
         end else begin
            check("shares_zero_outside_out", 32'({x0[i], x1[i], y0[i], y1[i]}), 32'd0);
         end
         ov_prev[i] = out_valid[i];
      end
   end

   // One full transaction on instance i. Reference: x1 is the XOR of every rx word,
   // x0 = X ^ x1 (likewise for Y); out_valid rises 4+R+stall edges after capture.
   task automatic run_txn(input int i, input logic [3:0] xv, input logic [3:0] yv,
                          input logic fixed, input logic [7:0] r0, input logic [7:0] r1,
                          input int stall_ld, input int stall_rf, input int bp);
      logic [3:0] sx, sy;
      logic [7:0] w;
      int         t, stalls, budget, ns;
      exp_t       e;
      x = xv;
      y = yv;
      in_valid[i]  = 1'b1;
      rnd_valid[i] = 1'b1;
      rnd = 8'($urandom);
      budget = 0;
      while (!in_ready[i] && budget < 50) begin step(); budget++; end
      if (!in_ready[i]) begin
         check("in_ready_timeout", 32'(in_ready[i]), 32'd1);
         in_valid[i] = 1'b0;
         return;
      end
      step();
      t = cyc;
      in_valid[i]  = 1'b0;
      rnd_valid[i] = 1'b0;
      x = 4'($urandom);
      y = 4'($urandom);
      sx = '0;
      sy = '0;
      stalls = 0;
      for (int k = 0; k <= rr(i); k++) begin
         budget = 0;
         while (!rnd_ready[i] && budget < 20) begin step(); budget++; end
         if (!rnd_ready[i]) begin
            check("rnd_ready_timeout", 32'(rnd_ready[i]), 32'd1);
            return;
         end
         ns = (k == 0) ? stall_ld : stall_rf;
         for (int s = 0; s < ns; s++) begin
            rnd = 8'($urandom);
            step();
            stalls++;
         end
         w = fixed ? ((k == 0) ? r0 : r1) : 8'($urandom);
         rnd = w;
         rnd_valid[i] = 1'b1;
         step();
         rnd_valid[i] = 1'b0;
         sx ^= w[3:0];
         sy ^= w[7:4];
      end
      cnt_model[i] = cnt_model[i] + rr(i) + 1;
      if (cnt_model[i] > cmax(i)) cnt_model[i] = cmax(i);
      e.inst   = i;
      e.shares = {xv ^ sx, sx, yv ^ sy, sy};
      e.rise   = t + 4 + rr(i) + stalls;
      e.cnt    = 16'(cnt_model[i]);
      sb.push_back(e);

      budget = 0;
      while (!out_valid[i] && budget < 30) begin step(); budget++; end
      if (!out_valid[i]) begin
         check("out_valid_timeout", 32'(out_valid[i]), 32'd1);
         return;
      end
      // Backpressure: offers on in/rnd must be ignored while the shares are held.
      rnd_valid[i] = 1'b1;
      for (int s = 0; s < bp; s++) begin
         in_valid[i] = (s % 2 == 0);
         x = 4'h1;
         step();
      end
      in_valid[i]  = 1'b0;
      rnd_valid[i] = 1'b0;
      out_ready[i] = 1'b1;
      step();
      out_ready[i] = 1'b0;
      check("in_ready_after_out", 32'(in_ready[i]), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < N; i++) begin
         in_valid[i] = 1'b0; rnd_valid[i] = 1'b0; out_ready[i] = 1'b0;
         cnt_model[i] = 0; ov_prev[i] = 1'b0;
      end
      x = '0; y = '0; rnd = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_out_valid", 32'(out_valid[0]), 32'd0);
      check("reset_rnd_ready", 32'(rnd_ready[0]), 32'd0);
      rst_n = 1'b1;
      #1;
      check("in_ready_before_first_edge", 32'(in_ready[0]), 32'd0);
      check("reset_rnd_cnt", 32'(cnt[0]), 32'd0);
      step();
      check("in_ready_after_first_edge", 32'(in_ready[0]), 32'd1);

      run_txn(0, 4'hA, 4'h5, 1'b1, 8'h3C, 8'h91, 0, 0, 0);
      run_txn(1, 4'hF, 4'h0, 1'b1, 8'h00, 8'h00, 0, 0, 0);
      run_txn(0, 4'hA, 4'h5, 1'b0, 8'h00, 8'h00, 3, 2, 0);
      run_txn(0, 4'($urandom), 4'($urandom), 1'b0, 8'h00, 8'h00, 0, 0, 6);
      run_txn(0, 4'h7, 4'h2, 1'b0, 8'h00, 8'h00, 0, 0, 0);
      for (int n = 0; n < 4; n++)
         run_txn(2, 4'($urandom), 4'($urandom), 1'b0, 8'h00, 8'h00, 0, 0, 0);

      for (int n = 0; n < 40; n++)
         run_txn(int'($urandom_range(0, N-1)), 4'($urandom), 4'($urandom), 1'b0, 8'h00, 8'h00,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));

      // Abort a transaction while it waits in REFRESH.
      x = 4'h9; y = 4'h6;
      in_valid[0] = 1'b1;
      while (!in_ready[0]) step();
      step();
      in_valid[0]  = 1'b0;
      rnd = 8'($urandom);
      rnd_valid[0] = 1'b1;
      step();
      rnd_valid[0] = 1'b0;
      step();
      check("refresh_rnd_ready", 32'(rnd_ready[0]), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_out_valid", 32'(out_valid[0]), 32'd0);
      check("abort_rnd_ready", 32'(rnd_ready[0]), 32'd0);
      check("abort_in_ready", 32'(in_ready[0]), 32'd0);
      check("abort_shares", 32'({x0[0], x1[0], y0[0], y1[0]}), 32'd0);
      check("abort_rnd_cnt", 32'(cnt[0]), 32'd0);
      for (int i = 0; i < N; i++) cnt_model[i] = 0;
      step();
      rst_n = 1'b1;
      step();
      check("recover_in_ready", 32'(in_ready[0]), 32'd1);
      check("recover_rnd_cnt", 32'(cnt[0]), 32'd0);
      run_txn(0, 4'h3, 4'hC, 1'b0, 8'h00, 8'h00, 1, 1, 2);

      repeat (3) step();
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
